instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the instruction/operand byte; SHALL be at least 8.
REQ-002 Parameter T_WIDTH, default 3: width of the T-state counter, with 2**T_WIDTH states.
REQ-003 Parameter OPND_MAX, default 2: maximum operand bytes per instruction, range 1..4.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 data_in  input  DATA_WIDTH  byte returned by memory for the current fetch.
REQ-007 mem_ready  input  1  memory has valid data_in this cycle.
REQ-008 hlt  input  1  external halt request.
REQ-009 resume  input  1  leave HALT state.
REQ-010 fetch_req  output  1  sequencer requests a byte at the PC address.
REQ-011 pc_inr  output  1  PC increment strobe.
REQ-012 ir_out  output  DATA_WIDTH  latched opcode.
REQ-013 opnd_out  output  OPND_MAX*DATA_WIDTH  latched operands; byte 0 in the LSBs.
REQ-014 exec_valid  output  1  one-cycle execute strobe.
REQ-015 t_state  output  T_WIDTH  cycle count within the current instruction.
REQ-016 halted  output  1  sequencer is in HALT.

Function
REQ-017 The state machine SHALL have five states: START, FETCH, OPND, EXEC, HALT.
REQ-018 START SHALL last exactly one cycle after reset release, then move to FETCH.
REQ-019 fetch_req SHALL equal 1 in FETCH and OPND, and 0 in all other states.
REQ-020 A byte SHALL be accepted in any cycle with fetch_req=1 and mem_ready=1; pc_inr SHALL be 1 only in accept cycles.
REQ-021 With mem_ready=0, state, ir_out and opnd_out SHALL hold, and wait states SHALL be unbounded.
REQ-022 On an accept in FETCH:
  - ir_out SHALL load data_in.
  - opnd_out SHALL clear to 0.
  - The operand count N SHALL be decoded from data_in.
REQ-023 Operand count N by opcode bits [7:6]:
  - 00 (MOV) → 0.
  - 01 (MVI) → 1.
  - 10 (ALU) → 0.
  - 11 (SYS) → OPND_MAX if bit 5 = 1, else 0.
REQ-024 If N=0, next state SHALL be EXEC; otherwise OPND.
REQ-025 In OPND, the k-th accepted byte (k=0..N-1) SHALL load opnd_out byte k; after byte N-1 the next state SHALL be EXEC.
REQ-026 EXEC SHALL last exactly one cycle with exec_valid=1; exec_valid SHALL be 0 in every other state.
REQ-027 The opcode whose value equals all-ones in bits [7:0] (HLT) SHALL go from EXEC to HALT; every other opcode SHALL go to FETCH.
REQ-028 t_state rules:
  - t_state SHALL be 0 in the FETCH entry cycle.
  - t_state SHALL increment every cycle the sequencer stays in FETCH, OPND or EXEC, including wait cycles.
  - t_state SHALL saturate at 2**T_WIDTH-1 and never wrap.
  - t_state SHALL be 0 in START and HALT.
REQ-029 hlt=1 SHALL be sampled only in the EXEC cycle, where it forces next state HALT; during FETCH and OPND it SHALL be ignored, so an instruction is never abandoned mid-fetch.
REQ-030 halted SHALL be 1 exactly while in HALT.
REQ-031 In HALT, resume=1 with hlt=0 SHALL move to FETCH next cycle; resume=1 with hlt=1 SHALL stay in HALT (hlt has priority).
REQ-032 ir_out and opnd_out SHALL hold their values through EXEC and HALT until the next FETCH accept.

Reset
REQ-033 On reset assertion, asynchronously:
  - State SHALL go to START.
  - ir_out, opnd_out and t_state SHALL clear to 0.
  - fetch_req, pc_inr, exec_valid and halted SHALL be 0.
REQ-034 Reset asserted mid-instruction (any state) SHALL discard the partial instruction; after release the sequence SHALL restart with START then FETCH, with no exec_valid for the discarded instruction.

Verification
REQ-035 Scenario: reset release, mem_ready=1, data_in=0x05 (MOV) → START 1 cycle; FETCH accept with pc_inr=1; EXEC with ir_out=0x05, exec_valid=1, t_state=1; then FETCH again.
REQ-036 Scenario: MVI 0x45 then operand 0xA7, mem_ready=1 → 2 pc_inr pulses; opnd_out byte0=0xA7; exec_valid on 3rd cycle after FETCH entry, with t_state=2.
REQ-037 Scenario: SYS 0xE0 with OPND_MAX=2, operands 0x34 then 0x12, mem_ready low for 3 cycles before each operand → opnd_out=0x1234; pc_inr=3 pulses total; exec_valid once; t_state=8, clipped to 7 when T_WIDTH=3.
REQ-038 Scenario: opcode 0xFF → halted=1 after EXEC; resume together with hlt=1 → stays halted; resume alone → FETCH next cycle with ir_out still 0xFF until the accept.
REQ-039 Scenario: hlt=1 pulsed during the OPND wait state of an MVI → instruction completes; hlt=1 held into EXEC → HALT; hlt during FETCH only → no effect.
REQ-040 Scenario: reset asserted in OPND after 1 of 2 operands → outputs clear immediately without a clock edge; no exec_valid; clean START/FETCH after release.

Source files
------------

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//
// Instruction fetch/execute sequencer. It fetches an opcode byte, then zero
// or more operand bytes depending on the opcode class, issues a one-cycle
// execute strobe, and either loops back to fetch or parks in HALT.
//
// Parameters
//   DATA_WIDTH  width of an instruction/operand byte (>= 8)
//   T_WIDTH     width of the T-state counter (saturating)
//   OPND_MAX    operand bytes carried by a SYS opcode with bit 5 set (1..4)
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   data_in     byte returned by memory for the current fetch
//   mem_ready   data_in is valid this cycle
//   hlt         halt request, honoured only in the execute cycle / in HALT
//   resume      leave HALT (ignored while hlt is also high)
//   fetch_req   a byte is wanted at the PC address (FETCH and OPND)
//   pc_inr      PC increment strobe, high exactly in byte-accept cycles
//   ir_out      latched opcode
//   opnd_out    latched operands, operand 0 in the least significant byte
//   exec_valid  one-cycle execute strobe
//   t_state     cycle count within the current instruction
//   halted      sequencer is in HALT
// ---------------------------------------------------------------------------
module instr_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int T_WIDTH    = 3,
  parameter int OPND_MAX   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic                           mem_ready,
  input  logic                           hlt,
  input  logic                           resume,
  output logic                           fetch_req,
  output logic                           pc_inr,
  output logic [DATA_WIDTH-1:0]          ir_out,
  output logic [OPND_MAX*DATA_WIDTH-1:0] opnd_out,
  output logic                           exec_valid,
  output logic [T_WIDTH-1:0]             t_state,
  output logic                           halted
);

  // Operand count and operand index both need to hold 0..OPND_MAX.
  localparam int CNT_W = $clog2(OPND_MAX + 1);
  localparam logic [T_WIDTH-1:0] T_MAX = {T_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_FETCH = 3'd1,
    S_OPND  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t                           r_state;
  state_t                           w_next;
  logic                             w_accept;
  logic                             w_last_opnd;
  logic [T_WIDTH-1:0]               w_t_next;
  logic [DATA_WIDTH-1:0]            r_ir;
  logic [OPND_MAX*DATA_WIDTH-1:0]   r_opnd;
  logic [CNT_W-1:0]                 r_opnd_n;
  logic [CNT_W-1:0]                 r_opnd_idx;
  logic [T_WIDTH-1:0]               r_t;

  // Operand count from the opcode class in bits [7:6]; only SYS with bit 5
  // set carries operands beyond the single MVI immediate.
  function automatic logic [CNT_W-1:0] f_opnd_count(input logic [7:0] op);
    logic [CNT_W-1:0] n;
    n = '0;
    case (op[7:6])
      2'b01:   n = CNT_W'(1);
      2'b11:   n = op[5] ? CNT_W'(OPND_MAX) : '0;
      default: n = '0;
    endcase
    return n;
  endfunction

  // Saturating increment: the T-state counter sticks at its maximum.
  function automatic logic [T_WIDTH-1:0] f_sat_inc(input logic [T_WIDTH-1:0] t);
    return (t == T_MAX) ? T_MAX : t + T_WIDTH'(1);
  endfunction

  // The last operand is the one whose index is N-1; only meaningful in OPND,
  // where N is known to be at least 1.
  assign w_last_opnd = (r_opnd_idx == (r_opnd_n - CNT_W'(1)));

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_START;
    end else begin
      r_state <= w_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and state-decoded outputs. Outputs depend on r_state only
  // (plus mem_ready for the accept strobe), so an asynchronous reset forcing
  // S_START drops them at once without waiting for a clock edge.
  // -------------------------------------------------------------------------
  always_comb begin
    w_next     = r_state;
    fetch_req  = 1'b0;
    pc_inr     = 1'b0;
    exec_valid = 1'b0;
    halted     = 1'b0;
    w_accept   = 1'b0;

    case (r_state)
      S_START: begin
        w_next = S_FETCH;
      end

      S_FETCH: begin
        fetch_req = 1'b1;
        if (mem_ready) begin
          w_accept = 1'b1;
          pc_inr   = 1'b1;
          w_next   = (f_opnd_count(data_in[7:0]) == '0) ? S_EXEC : S_OPND;
        end
      end

      S_OPND: begin
        fetch_req = 1'b1;
        if (mem_ready) begin
          w_accept = 1'b1;
          pc_inr   = 1'b1;
          if (w_last_opnd) begin
            w_next = S_EXEC;
          end
        end
      end

      // hlt is only looked at here, so an instruction already being fetched
      // always runs to completion.
      S_EXEC: begin
        exec_valid = 1'b1;
        if (hlt || (r_ir[7:0] == 8'hFF)) begin
          w_next = S_HALT;
        end else begin
          w_next = S_FETCH;
        end
      end

      // hlt wins over resume so a held halt request keeps the core parked.
      S_HALT: begin
        halted = 1'b1;
        if (resume && !hlt) begin
          w_next = S_FETCH;
        end
      end

      default: begin
        w_next = S_START;
      end
    endcase
  end

  // T-state: zero on entering FETCH from outside the instruction, counts
  // through FETCH/OPND/EXEC including wait cycles, zero in START and HALT.
  always_comb begin
    w_t_next = '0;
    case (w_next)
      S_FETCH: w_t_next = (r_state == S_FETCH) ? f_sat_inc(r_t) : '0;
      S_OPND,
      S_EXEC:  w_t_next = f_sat_inc(r_t);
      default: w_t_next = '0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Instruction / operand latches and T-state counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir       <= '0;
      r_opnd     <= '0;
      r_opnd_n   <= '0;
      r_opnd_idx <= '0;
      r_t        <= '0;
    end else begin
      r_t <= w_t_next;
      if (w_accept && (r_state == S_FETCH)) begin
        // A new opcode invalidates whatever operands the previous
        // instruction left behind.
        r_ir       <= data_in;
        r_opnd     <= '0;
        r_opnd_n   <= f_opnd_count(data_in[7:0]);
        r_opnd_idx <= '0;
      end else if (w_accept && (r_state == S_OPND)) begin
        for (int k = 0; k < OPND_MAX; k++) begin
          if (k == int'(r_opnd_idx)) begin
            r_opnd[k*DATA_WIDTH +: DATA_WIDTH] <= data_in;
          end
        end
        r_opnd_idx <= r_opnd_idx + CNT_W'(1);
      end
    end
  end

  assign ir_out   = r_ir;
  assign opnd_out = r_opnd;
  assign t_state  = r_t;

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
//
// Directed bench for instr_sequencer with default parameters
// (DATA_WIDTH=8, T_WIDTH=3, OPND_MAX=2). Inputs change 2 time units after
// the rising edge; outputs are sampled 1 time unit after that.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

  logic        clk;
  logic        reset;
  logic [7:0]  data_in;
  logic        mem_ready;
  logic        hlt;
  logic        resume;
  logic        fetch_req;
  logic        pc_inr;
  logic [7:0]  ir_out;
  logic [15:0] opnd_out;
  logic        exec_valid;
  logic [2:0]  t_state;
  logic        halted;

  int n_checks;
  int n_pass;

  instr_sequencer #(
    .DATA_WIDTH(8),
    .T_WIDTH   (3),
    .OPND_MAX  (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .mem_ready (mem_ready),
    .hlt       (hlt),
    .resume    (resume),
    .fetch_req (fetch_req),
    .pc_inr    (pc_inr),
    .ir_out    (ir_out),
    .opnd_out  (opnd_out),
    .exec_valid(exec_valid),
    .t_state   (t_state),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Advance to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    n_checks++; if (fetch_req !== 1'b0) $display("FAIL rst_fetch_req: got %b want 0", fetch_req); else n_pass++;
    n_checks++; if (pc_inr !== 1'b0) $display("FAIL rst_pc_inr: got %b want 0", pc_inr); else n_pass++;
    n_checks++; if (exec_valid !== 1'b0) $display("FAIL rst_exec_valid: got %b want 0", exec_valid); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b want 0", halted); else n_pass++;
    n_checks++; if (ir_out !== 8'h00) $display("FAIL rst_ir_out: got %h want 00", ir_out); else n_pass++;
    n_checks++; if (opnd_out !== 16'h0000) $display("FAIL rst_opnd_out: got %h want 0000", opnd_out); else n_pass++;
    n_checks++; if (t_state !== 3'd0) $display("FAIL rst_t_state: got %0d want 0", t_state); else n_pass++;
    cyc();
    cyc();
    n_checks++; if (fetch_req !== 1'b0) $display("FAIL rst_hold_fetch_req: got %b want 0", fetch_req); else n_pass++;
  endtask

  // Reset release, MOV 0x05 with memory always ready.
  task automatic test_mov();
    data_in   = 8'h05;
    mem_ready = 1'b1;
    reset     = 1'b0;
    #1;
    n_checks++; if (fetch_req !== 1'b0) $display("FAIL mov_start_fetch_req: got %b want 0", fetch_req); else n_pass++;
    n_checks++; if (t_state !== 3'd0) $display("FAIL mov_start_t: got %0d want 0", t_state); else n_pass++;
    cyc(); #1;
    n_checks++; if (fetch_req !== 1'b1) $display("FAIL mov_fetch_req: got %b want 1", fetch_req); else n_pass++;
    n_checks++; if (pc_inr !== 1'b1) $display("FAIL mov_pc_inr: got %b want 1", pc_inr); else n_pass++;
    n_checks++; if (t_state !== 3'd0) $display("FAIL mov_fetch_t: got %0d want 0", t_state); else n_pass++;
    cyc(); #1;
    n_checks++; if (exec_valid !== 1'b1) $display("FAIL mov_exec_valid: got %b want 1", exec_valid); else n_pass++;
    n_checks++; if (ir_out !== 8'h05) $display("FAIL mov_ir_out: got %h want 05", ir_out); else n_pass++;
    n_checks++; if (t_state !== 3'd1) $display("FAIL mov_exec_t: got %0d want 1", t_state); else n_pass++;
    n_checks++; if (pc_inr !== 1'b0) $display("FAIL mov_exec_pc_inr: got %b want 0", pc_inr); else n_pass++;
    cyc(); #1;
    n_checks++; if (fetch_req !== 1'b1) $display("FAIL mov_refetch: got %b want 1", fetch_req); else n_pass++;
    n_checks++; if (exec_valid !== 1'b0) $display("FAIL mov_refetch_exec: got %b want 0", exec_valid); else n_pass++;
    n_checks++; if (t_state !== 3'd0) $display("FAIL mov_refetch_t: got %0d want 0", t_state); else n_pass++;
  endtask

  // MVI 0x45 with immediate 0xA7, no wait states.
  task automatic test_mvi();
    int pulses;
    pulses    = 0;
    data_in   = 8'h45;
    mem_ready = 1'b1;
    #1;
    if (pc_inr === 1'b1) pulses++;
    cyc();
    data_in = 8'hA7;
    #1;
    if (pc_inr === 1'b1) pulses++;
    n_checks++; if (fetch_req !== 1'b1) $display("FAIL mvi_opnd_fetch_req: got %b want 1", fetch_req); else n_pass++;
    n_checks++; if (t_state !== 3'd1) $display("FAIL mvi_opnd_t: got %0d want 1", t_state); else n_pass++;
    cyc(); #1;
    n_checks++; if (exec_valid !== 1'b1) $display("FAIL mvi_exec_valid: got %b want 1", exec_valid); else n_pass++;
    n_checks++; if (t_state !== 3'd2) $display("FAIL mvi_exec_t: got %0d want 2", t_state); else n_pass++;
    n_checks++; if (opnd_out !== 16'h00A7) $display("FAIL mvi_opnd_out: got %h want 00a7", opnd_out); else n_pass++;
    n_checks++; if (ir_out !== 8'h45) $display("FAIL mvi_ir_out: got %h want 45", ir_out); else n_pass++;
    n_checks++; if (pulses !== 2) $display("FAIL mvi_pc_pulses: got %0d want 2", pulses); else n_pass++;
    cyc(); #1;
    n_checks++; if (fetch_req !== 1'b1) $display("FAIL mvi_refetch: got %b want 1", fetch_req); else n_pass++;
  endtask

  // SYS 0xE0 with two operands, three wait cycles before each; t saturates.
  task automatic test_sys_wait();
    int pulses;
    int execs;
    logic [2:0] exp_t;
    pulses    = 0;
    execs     = 0;
    data_in   = 8'hE0;
    mem_ready = 1'b1;
    #1;
    if (pc_inr === 1'b1) pulses++;
    cyc();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      exp_t = 3'(i + 1);
      if (pc_inr === 1'b1) pulses++;
      if (exec_valid === 1'b1) execs++;
      n_checks++; if (t_state !== exp_t) $display("FAIL sys_wait0_t: got %0d want %0d", t_state, exp_t); else n_pass++;
      n_checks++; if (fetch_req !== 1'b1) $display("FAIL sys_wait0_fetch_req: got %b want 1", fetch_req); else n_pass++;
      cyc();
    end
    data_in   = 8'h34;
    mem_ready = 1'b1;
    #1;
    if (pc_inr === 1'b1) pulses++;
    n_checks++; if (t_state !== 3'd4) $display("FAIL sys_acc0_t: got %0d want 4", t_state); else n_pass++;
    cyc();
    mem_ready = 1'b0;
    data_in   = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      #1;
      exp_t = 3'(i + 5);
      if (pc_inr === 1'b1) pulses++;
      if (exec_valid === 1'b1) execs++;
      n_checks++; if (t_state !== exp_t) $display("FAIL sys_wait1_t: got %0d want %0d", t_state, exp_t); else n_pass++;
      n_checks++; if (opnd_out !== 16'h0034) $display("FAIL sys_wait1_hold: got %h want 0034", opnd_out); else n_pass++;
      cyc();
    end
    data_in   = 8'h12;
    mem_ready = 1'b1;
    #1;
    if (pc_inr === 1'b1) pulses++;
    n_checks++; if (t_state !== 3'd7) $display("FAIL sys_acc1_t: got %0d want 7", t_state); else n_pass++;
    cyc(); #1;
    if (pc_inr === 1'b1) pulses++;
    if (exec_valid === 1'b1) execs++;
    n_checks++; if (opnd_out !== 16'h1234) $display("FAIL sys_opnd_out: got %h want 1234", opnd_out); else n_pass++;
    n_checks++; if (t_state !== 3'd7) $display("FAIL sys_exec_t_sat: got %0d want 7", t_state); else n_pass++;
    n_checks++; if (ir_out !== 8'hE0) $display("FAIL sys_ir_out: got %h want e0", ir_out); else n_pass++;
    cyc(); #1;
    if (exec_valid === 1'b1) execs++;
    n_checks++; if (pulses !== 3) $display("FAIL sys_pc_pulses: got %0d want 3", pulses); else n_pass++;
    n_checks++; if (execs !== 1) $display("FAIL sys_exec_count: got %0d want 1", execs); else n_pass++;
    n_checks++; if (t_state !== 3'd0) $display("FAIL sys_refetch_t: got %0d want 0", t_state); else n_pass++;
  endtask

  // HLT opcode 0xFF (a SYS with two operands), then resume handling.
  task automatic test_hlt_opcode();
    data_in   = 8'hFF;
    mem_ready = 1'b1;
    cyc();
    data_in = 8'h11;
    cyc();
    data_in = 8'h22;
    cyc(); #1;
    n_checks++; if (exec_valid !== 1'b1) $display("FAIL hlt_exec_valid: got %b want 1", exec_valid); else n_pass++;
    n_checks++; if (opnd_out !== 16'h2211) $display("FAIL hlt_opnd_out: got %h want 2211", opnd_out); else n_pass++;
    cyc(); #1;
    n_checks++; if (halted !== 1'b1) $display("FAIL hlt_halted: got %b want 1", halted); else n_pass++;
    n_checks++; if (fetch_req !== 1'b0) $display("FAIL hlt_fetch_req: got %b want 0", fetch_req); else n_pass++;
    n_checks++; if (t_state !== 3'd0) $display("FAIL hlt_t: got %0d want 0", t_state); else n_pass++;
    n_checks++; if (ir_out !== 8'hFF) $display("FAIL hlt_ir_hold: got %h want ff", ir_out); else n_pass++;
    resume = 1'b1;
    hlt    = 1'b1;
    cyc(); #1;
    n_checks++; if (halted !== 1'b1) $display("FAIL hlt_priority: got %b want 1", halted); else n_pass++;
    hlt       = 1'b0;
    mem_ready = 1'b0;
    cyc();
    resume = 1'b0;
    #1;
    n_checks++; if (halted !== 1'b0) $display("FAIL hlt_resume_halted: got %b want 0", halted); else n_pass++;
    n_checks++; if (fetch_req !== 1'b1) $display("FAIL hlt_resume_fetch: got %b want 1", fetch_req); else n_pass++;
    n_checks++; if (ir_out !== 8'hFF) $display("FAIL hlt_resume_ir: got %h want ff", ir_out); else n_pass++;
    n_checks++; if (t_state !== 3'd0) $display("FAIL hlt_resume_t: got %0d want 0", t_state); else n_pass++;
    cyc(); #1;
    n_checks++; if (t_state !== 3'd1) $display("FAIL hlt_fetch_wait_t: got %0d want 1", t_state); else n_pass++;
    n_checks++; if (ir_out !== 8'hFF) $display("FAIL hlt_fetch_wait_ir: got %h want ff", ir_out); else n_pass++;
    data_in   = 8'h80;
    mem_ready = 1'b1;
    cyc(); #1;
    n_checks++; if (ir_out !== 8'h80) $display("FAIL alu_ir_out: got %h want 80", ir_out); else n_pass++;
    n_checks++; if (opnd_out !== 16'h0000) $display("FAIL alu_opnd_clear: got %h want 0000", opnd_out); else n_pass++;
    n_checks++; if (exec_valid !== 1'b1) $display("FAIL alu_exec_valid: got %b want 1", exec_valid); else n_pass++;
    cyc();
  endtask

  // hlt ignored during FETCH and OPND; honoured when held into EXEC.
  task automatic test_hlt_ignored();
    hlt       = 1'b1;
    data_in   = 8'h45;
    mem_ready = 1'b1;
    #1;
    n_checks++; if (pc_inr !== 1'b1) $display("FAIL hign_fetch_pc_inr: got %b want 1", pc_inr); else n_pass++;
    cyc();
    mem_ready = 1'b0;
    #1;
    n_checks++; if (fetch_req !== 1'b1) $display("FAIL hign_opnd_fetch_req: got %b want 1", fetch_req); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL hign_opnd_halted: got %b want 0", halted); else n_pass++;
    cyc();
    hlt       = 1'b0;
    mem_ready = 1'b1;
    data_in   = 8'h5A;
    #1;
    n_checks++; if (pc_inr !== 1'b1) $display("FAIL hign_opnd_accept: got %b want 1", pc_inr); else n_pass++;
    cyc(); #1;
    n_checks++; if (exec_valid !== 1'b1) $display("FAIL hign_exec_valid: got %b want 1", exec_valid); else n_pass++;
    n_checks++; if (opnd_out !== 16'h005A) $display("FAIL hign_opnd_out: got %h want 005a", opnd_out); else n_pass++;
    cyc(); #1;
    n_checks++; if (fetch_req !== 1'b1) $display("FAIL hign_no_halt: got %b want 1", fetch_req); else n_pass++;
    hlt     = 1'b1;
    data_in = 8'h00;
    cyc(); #1;
    n_checks++; if (exec_valid !== 1'b1) $display("FAIL hheld_exec_valid: got %b want 1", exec_valid); else n_pass++;
    cyc(); #1;
    n_checks++; if (halted !== 1'b1) $display("FAIL hheld_halted: got %b want 1", halted); else n_pass++;
    hlt    = 1'b0;
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    #1;
    n_checks++; if (fetch_req !== 1'b1) $display("FAIL hheld_resume_fetch: got %b want 1", fetch_req); else n_pass++;
  endtask

  // Reset asserted in OPND after the first of two operands.
  task automatic test_reset_mid();
    int execs;
    execs     = 0;
    data_in   = 8'hE0;
    mem_ready = 1'b1;
    cyc();
    data_in = 8'h34;
    cyc();
    mem_ready = 1'b0;
    #1;
    n_checks++; if (opnd_out !== 16'h0034) $display("FAIL rmid_partial: got %h want 0034", opnd_out); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (fetch_req !== 1'b0) $display("FAIL rmid_fetch_req: got %b want 0", fetch_req); else n_pass++;
    n_checks++; if (ir_out !== 8'h00) $display("FAIL rmid_ir_out: got %h want 00", ir_out); else n_pass++;
    n_checks++; if (opnd_out !== 16'h0000) $display("FAIL rmid_opnd_out: got %h want 0000", opnd_out); else n_pass++;
    n_checks++; if (t_state !== 3'd0) $display("FAIL rmid_t: got %0d want 0", t_state); else n_pass++;
    mem_ready = 1'b1;
    data_in   = 8'h12;
    cyc(); #1;
    if (exec_valid === 1'b1) execs++;
    cyc();
    reset   = 1'b0;
    data_in = 8'h05;
    #1;
    if (exec_valid === 1'b1) execs++;
    n_checks++; if (fetch_req !== 1'b0) $display("FAIL rmid_start: got %b want 0", fetch_req); else n_pass++;
    cyc(); #1;
    if (exec_valid === 1'b1) execs++;
    n_checks++; if (fetch_req !== 1'b1) $display("FAIL rmid_fetch: got %b want 1", fetch_req); else n_pass++;
    n_checks++; if (execs !== 0) $display("FAIL rmid_no_exec: got %0d want 0", execs); else n_pass++;
    cyc(); #1;
    n_checks++; if (exec_valid !== 1'b1) $display("FAIL rmid_clean_exec: got %b want 1", exec_valid); else n_pass++;
    n_checks++; if (ir_out !== 8'h05) $display("FAIL rmid_clean_ir: got %h want 05", ir_out); else n_pass++;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b0;
    data_in   = 8'h00;
    mem_ready = 1'b0;
    hlt       = 1'b0;
    resume    = 1'b0;
    test_reset();
    test_mov();
    test_mvi();
    test_sys_wait();
    test_hlt_opcode();
    test_hlt_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
